// File: rtl/seq_chunk_adder_if.sv
// Handshake bus for seq_chunk_adder.
// master: drives start/sub/a/b and observes the result.
// slave : the adder; samples the request and drives busy/done/sum/cout/ovf.
interface seq_chunk_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor that pushes CHUNK bits per clock through one
// CHUNK-bit slice, carrying between chunks in a register. WIDTH/CHUNK cycles
// per operation, LSB chunk first.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - seq_chunk_adder_if.slave: start/sub/a/b in, busy/done/sum/cout/ovf out
// WIDTH must be >= 2 and a multiple of CHUNK; the interface WIDTH must match.
module seq_chunk_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst,
    seq_chunk_adder_if.slave   bus
);

    // Bit offset of the current chunk; sized to index the WIDTH-bit vectors.
    localparam int unsigned OFFW = $clog2(WIDTH);
    localparam logic [OFFW-1:0] LAST_OFF = OFFW'(WIDTH - CHUNK);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;       // already inverted for subtraction
    logic [WIDTH-1:0] sum_q;
    logic [OFFW-1:0]  off_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic [CHUNK:0]   slice_full;
    logic             slice_cout;
    logic             msb_cin;

    // CHUNK-bit full-adder slice on the current chunk.
    always_comb begin
        a_chunk    = a_q[off_q +: CHUNK];
        b_chunk    = b_q[off_q +: CHUNK];
        slice_full = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        s_chunk    = slice_full[CHUNK-1:0];
        slice_cout = slice_full[CHUNK];
        // Carry into the slice MSB recovered from its sum bit; for CHUNK=1
        // this reduces to carry_q.
        msb_cin    = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1];
    end

    // Control FSM and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            off_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub;   // +1 completes the two's complement
                        off_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_q[off_q +: CHUNK] <= s_chunk;
                    carry_q               <= slice_cout;
                    off_q                 <= off_q + OFFW'(CHUNK);
                    if (off_q == LAST_OFF) begin
                        cout_q <= slice_cout;
                        ovf_q  <= msb_cin ^ slice_cout;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised multi-cycle adder/subtractor. It is the next generation of the team's 4-bit ripple carry adder: width is a parameter, it subtracts as well as adds, it flags signed overflow, and it uses a start/done handshake. It processes CHUNK bits per clock through a CHUNK-bit full-adder slice with a registered carry between chunks, so a wide add costs one small adder plus WIDTH/CHUNK cycles. It sits in the datapath wherever area matters more than single-cycle latency.

## Interface
- WIDTH, default 16: operand and result width in bits; must be ≥ 2.
- CHUNK, default 4: bits added per cycle; must divide WIDTH exactly. N = WIDTH/CHUNK is the number of chunk cycles.
- clk  input  1  the single clock. All state changes on the rising edge.
- rst  input  1  reset. Synchronous, active-high.
- start  input  1  request a new operation. Sampled only while the block is idle.
- sub  input  1  0 = A+B, 1 = A−B. Sampled with start.
- a  input  WIDTH  operand A, unsigned or two's complement. Sampled with start.
- b  input  WIDTH  operand B. Sampled with start.
- busy  output  1  operation in progress; start is ignored while busy is high.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. For subtraction it means "no borrow" (1 iff a ≥ b unsigned).
- ovf  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- States: IDLE, RUN.
- IDLE
  - On a rising edge with start=1:
    - latch a;
    - latch b, or ~b when sub=1;
    - load carry = sub;
    - clear the chunk index and the sum register;
    - go to RUN.
- RUN
  - Each edge adds chunk i of the latched A and B to the carry register through the CHUNK-bit slice.
  - The slice result is written to sum[i·CHUNK +: CHUNK], and the carry register is updated.
  - Chunks go LSB first, i = 0..N−1.
  - When i = N−1:
    - write cout = slice carry-out;
    - write ovf = carry into bit WIDTH−1 XOR slice carry-out;
    - pulse done;
    - return to IDLE.
- The internal carry into the MSB comes from bit CHUNK−2 of the last slice. When CHUNK=1 it is the carry register itself.
- The sum, cout and ovf outputs only change in two cases: a new start is accepted (sum clears to 0), or a chunk writes them. After done they hold until the next accepted start.
- cout and ovf clear to 0 when a start is accepted.
- Operand inputs may change freely after the start edge; they are not used again.
- start held high continuously causes back-to-back operations, each re-sampling the inputs.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state=IDLE.
- rst asserted at any edge, including mid-RUN:
  - aborts the operation with no done;
  - forces the reset values on the next edge;
  - rst has priority over start.
- Let start be accepted at edge k.
  - busy=1 after edge k.
  - Chunk writes happen on edges k+1 … k+N.
  - After edge k+N: done=1, busy=0, and sum, cout and ovf are final.
  - Latency from start edge to done is N cycles. With CHUNK=WIDTH it is 1 cycle.
- done is high for exactly one cycle, the cycle after edge k+N.
- start=1 during the done cycle is accepted at edge k+N+1 (the block is IDLE). The maximum throughput is one result per N+1 cycles.
- start=1 while busy has no effect and is not queued.
- Partial sum bits are visible on sum during RUN. Consumers use them only after done.

## Test plan
- WIDTH=16, CHUNK=4; start with a=0xFFFF, b=0x0001, sub=0 at edge k → done after edge k+4, sum=0x0000, cout=1, ovf=0, busy high for edges k+1..k+4.
- sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0. Then a=0x0007, b=0x0005 → sum=0x0002, cout=1.
- Signed overflow with a=0x7FFF, b=0x0001, add → sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x0001, sub → sum=0x7FFF, ovf=1, cout=1.
- Handshake checks:
  - start pulsed again at edges k+1..k+3 with different operands → ignored; result is still from the first operands; exactly one done.
  - start in the done cycle → second result after N more edges.
- rst at edge k+2 mid-RUN → no done; all outputs 0 the next cycle. A start accepted afterwards gives a correct result.
- Exhaustive sweeps against the golden results a+b and a−b mod 2^WIDTH, with cout and ovf, for all 256 operand pairs × both modes:
  - WIDTH=4, CHUNK=1: latency 4.
  - WIDTH=4, CHUNK=4: latency 1.
  - WIDTH=4, CHUNK=2: latency 2.
